// File: rtl/msix_pkg.sv
// msix_pkg: shared FSM states, AXI response codes and address-map defaults for the MSI-X AXI-Lite bridge.
package msix_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ACC, S_WR_DEC, S_WR_EXEC, S_WR_RESP,
    S_RMW_RD, S_RMW_WAIT, S_RMW_MERGE,
    S_RD_ACC, S_RD_ADDR, S_RD_WAIT, S_RD_CAP, S_RD_RESP
  } state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int unsigned MEM_SIZE_DEFAULT = 512;
  localparam logic [31:0] PBA_OFFSET_DEFAULT = 32'h100;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_d, input logic [31:0] new_d, input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/msix_axil_decode.sv
// msix_axil_decode: classifies a byte address as inside the MSI-X window and, if so, inside the read-only PBA.
module msix_axil_decode
  import msix_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH     = 9,
  parameter int unsigned C_MEM_SIZE_BYTES = MEM_SIZE_DEFAULT,
  parameter logic [31:0] C_PBA_OFFSET     = PBA_OFFSET_DEFAULT
) (
  input  logic [C_ADDR_WIDTH-1:0] i_addr,
  output logic                    o_in_range,
  output logic                    o_is_pba
);
  logic [31:0] w_addr;
  assign w_addr = 32'(i_addr);
  assign o_in_range = w_addr < C_MEM_SIZE_BYTES;
  assign o_is_pba = o_in_range && w_addr >= C_PBA_OFFSET;
endmodule

// File: rtl/msix_axil_bridge.sv
// msix_axil_bridge: AXI4-Lite slave serialising host BAR accesses onto the MSI-X table/PBA memory port.
// Define MSIX_BRIDGE_RMW_EN to service partial-strobe writes by read-modify-write instead of SLVERR.
module msix_axil_bridge
  import msix_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH     = 9,
  parameter int unsigned C_DATA_WIDTH     = 32,
  parameter int unsigned C_MEM_SIZE_BYTES = MEM_SIZE_DEFAULT,
  parameter logic [31:0] C_PBA_OFFSET     = PBA_OFFSET_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [C_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [C_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [C_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [C_ADDR_WIDTH-1:0]   m_mem_waddr,
  output logic [C_ADDR_WIDTH-1:0]   m_mem_raddr,
  output logic [C_DATA_WIDTH-1:0]   m_mem_wdata,
  input  logic [C_DATA_WIDTH-1:0]   m_mem_rdata,
  output logic                      m_mem_we_norread
);
  localparam logic [C_ADDR_WIDTH-1:0] ALIGN = ~C_ADDR_WIDTH'(3);
  state_t r_state;
  logic r_rd_pri, r_awready, r_wready, r_arready, r_bvalid, r_rvalid, r_we;
  logic [1:0] r_bresp, r_rresp;
  logic [C_ADDR_WIDTH-1:0] r_addr, r_waddr, r_raddr;
  logic [C_DATA_WIDTH-1:0] r_wdata, r_rdata, r_mem_wdata;
  logic [C_DATA_WIDTH/8-1:0] r_strb;
  logic w_wr_elig, w_in_range, w_is_pba;
  logic [C_ADDR_WIDTH-1:0] w_dec_addr;
  assign w_wr_elig = s_axil_awvalid && s_axil_wvalid;
  // One decoder serves both paths: the live read address while it is accepted, the captured write address otherwise.
  assign w_dec_addr = (r_state == S_RD_ACC) ? (s_axil_araddr & ALIGN) : r_addr;
  msix_axil_decode #(
    .C_ADDR_WIDTH(C_ADDR_WIDTH), .C_MEM_SIZE_BYTES(C_MEM_SIZE_BYTES), .C_PBA_OFFSET(C_PBA_OFFSET)
  ) u_decode (
    .i_addr(w_dec_addr), .o_in_range(w_in_range), .o_is_pba(w_is_pba)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rd_pri <= 1'b0;
      r_awready <= 1'b0;
      r_wready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_we <= 1'b0;
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
      r_addr <= '0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mem_wdata <= '0;
      r_strb <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_wr_elig && (!r_rd_pri || !s_axil_arvalid)) begin
            r_awready <= 1'b1;
            r_wready <= 1'b1;
            r_rd_pri <= ~r_rd_pri;
            r_state <= S_WR_ACC;
          end else if (s_axil_arvalid) begin
            r_arready <= 1'b1;
            r_rd_pri <= ~r_rd_pri;
            r_state <= S_RD_ACC;
          end
        S_WR_ACC: begin
          r_awready <= 1'b0;
          r_wready <= 1'b0;
          r_addr <= s_axil_awaddr & ALIGN;
          r_wdata <= s_axil_wdata;
          r_strb <= s_axil_wstrb;
          r_state <= S_WR_DEC;
        end
        S_WR_DEC:
          if (w_in_range && !w_is_pba && r_strb == 4'hF) begin
            r_we <= 1'b1;
            r_waddr <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state <= S_WR_EXEC;
`ifdef MSIX_BRIDGE_RMW_EN
          end else if (w_in_range && !w_is_pba && r_strb != 4'h0) begin
            r_raddr <= r_addr;
            r_state <= S_RMW_RD;
          end else begin
            r_bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
`else
          end else begin
            r_bresp <= (!w_in_range || (!w_is_pba && r_strb != 4'h0)) ? RESP_SLVERR : RESP_OKAY;
`endif
            r_bvalid <= 1'b1;
            r_state <= S_WR_RESP;
          end
`ifdef MSIX_BRIDGE_RMW_EN
        S_RMW_RD: r_state <= S_RMW_WAIT;
        S_RMW_WAIT: r_state <= S_RMW_MERGE;
        S_RMW_MERGE: begin
          r_we <= 1'b1;
          r_waddr <= r_addr;
          r_mem_wdata <= merge_bytes(m_mem_rdata, r_wdata, r_strb);
          r_state <= S_WR_EXEC;
        end
`endif
        S_WR_EXEC: begin
          r_we <= 1'b0;
          r_bresp <= RESP_OKAY;
          r_bvalid <= 1'b1;
          r_state <= S_WR_RESP;
        end
        S_WR_RESP:
          if (s_axil_bready) begin
            r_bvalid <= 1'b0;
            r_state <= S_IDLE;
          end
        S_RD_ACC: begin
          r_arready <= 1'b0;
          if (w_in_range) begin
            r_raddr <= w_dec_addr;
            r_state <= S_RD_ADDR;
          end else begin
            r_rdata <= '0;
            r_rresp <= RESP_SLVERR;
            r_rvalid <= 1'b1;
            r_state <= S_RD_RESP;
          end
        end
        S_RD_ADDR: r_state <= S_RD_WAIT;
        S_RD_WAIT: r_state <= S_RD_CAP;
        S_RD_CAP: begin
          r_rdata <= m_mem_rdata;
          r_rresp <= RESP_OKAY;
          r_rvalid <= 1'b1;
          r_state <= S_RD_RESP;
        end
        S_RD_RESP:
          if (s_axil_rready) begin
            r_rvalid <= 1'b0;
            r_state <= S_IDLE;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign s_axil_awready = r_awready;
  assign s_axil_wready = r_wready;
  assign s_axil_arready = r_arready;
  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp = r_bresp;
  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rresp = r_rresp;
  assign s_axil_rdata = r_rdata;
  assign m_mem_waddr = r_waddr;
  assign m_mem_raddr = r_raddr;
  assign m_mem_wdata = r_mem_wdata;
  assign m_mem_we_norread = r_we;
endmodule

// File: tb/tb_msix_axil_bridge.sv
// tb_msix_axil_bridge: randomized AXI-Lite traffic against a word-array reference model of the MSI-X window.
// Built with a 10-bit address so that out-of-window addresses (>= 0x200) are reachable.
module tb_msix_axil_bridge;
`ifdef MSIX_BRIDGE_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] awaddr = '0, araddr = '0, waddr, raddr;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0, rdata, mwdata, mem_rdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, we;
  logic [1:0] bresp, rresp;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:127];
  logic [9:0] exp_raddr = '0, last_waddr = '0;
  logic [31:0] last_wdata = '0;
  int we_cnt = 0, both_cnt = 0, n_checks = 0, n_errs = 0;
  logic [93:0] outs;
  assign outs = {awready, wready, arready, bvalid, rvalid, we, bresp, rresp, rdata, raddr, waddr, mwdata};

  msix_axil_bridge #(.C_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .m_mem_waddr(waddr), .m_mem_raddr(raddr), .m_mem_wdata(mwdata),
    .m_mem_rdata(mem_rdata), .m_mem_we_norread(we)
  );

  always #5 clk = ~clk;

  // BRAM port B: read-before-write, data one cycle after the address is sampled
  always @(posedge clk) begin
    mem_rdata <= mem[raddr[9:2]];
    if (we) mem[waddr[9:2]] = mwdata;
  end

  always @(posedge clk) if (rst_n) begin
    if (we) begin
      we_cnt++;
      last_waddr = waddr;
      last_wdata = mwdata;
    end
    if (bvalid && rvalid) both_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    exp_raddr = '0;
    repeat (3) tick();
    check("reset_outs", outs, 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [9:0] a, input int stall);
    logic [31:0] ed;
    logic [1:0] er;
    int n, w0;
    ed = (a >= 10'd512) ? 32'h0 : ref_mem[a[8:2]];
    er = (a >= 10'd512) ? 2'b10 : 2'b00;
    if (a < 10'd512) exp_raddr = {a[9:2], 2'b00};
    w0 = we_cnt;
    araddr = a; arvalid = 1'b1; n = 0;
    do begin tick(); n++; end while (!arready && n < 20);
    check("ar_grant", arready, 1);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    check("r_wait", rvalid, 1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("r_hold", {rvalid, rresp, rdata, awready, arready}, {1'b1, er, ed, 2'b00});
    end
    check("rresp", rresp, er);
    check("rdata", rdata, ed);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r_drop", rvalid, 0);
    check("r_nowrite", we_cnt - w0, 0);
    check("raddr", raddr, exp_raddr);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s, input int stall);
    logic [1:0] er;
    logic [31:0] nw;
    int ep, n, w0;
    er = 2'b00; ep = 0; nw = '0;
    if (a >= 10'd512) er = 2'b10;
    else if (a < 10'h100 && s != 4'h0) begin
      if (s == 4'hF || RMW) begin
        nw = ref_mem[a[8:2]];
        for (int i = 0; i < 4; i++) if (s[i]) nw[8*i +: 8] = d[8*i +: 8];
        ref_mem[a[8:2]] = nw;
        ep = 1;
        if (s != 4'hF) exp_raddr = {a[9:2], 2'b00};
      end else er = 2'b10;
    end
    w0 = we_cnt;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    do begin tick(); n++; end while (!awready && n < 20);
    check("aw_grant", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("b_wait", bvalid, 1);
    for (int i = 0; i < stall; i++) begin
      if (i == 0) begin araddr = a; arvalid = 1'b1; end
      tick();
      check("b_hold", {bvalid, bresp, arready, awready}, {1'b1, er, 2'b00});
    end
    check("bresp", bresp, er);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_drop", bvalid, 0);
    check("we_pulses", we_cnt - w0, ep);
    if (ep != 0) check("waddr_wdata", {last_waddr, last_wdata}, {a[9:2], 2'b00, nw});
    if (stall > 0) rd(a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int gs [4];
    int g, n, w0;
    bit dw, dr;
    logic [9:0] a;
    logic [3:0] s;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
    reset_dut();
    // full write then readback
    wr(10'h010, 32'hDEADBEEF, 4'hF, 0);
    check("w1_waddr", last_waddr, 10'h010);
    check("w1_wdata", last_wdata, 32'hDEADBEEF);
    rd(10'h010, 0);
    check("r1_const", rdata, 32'hDEADBEEF);
    // PBA is read-only to the host
    mem[65] = 32'hCAFE0104; ref_mem[65] = 32'hCAFE0104;
    wr(10'h104, 32'h55555555, 4'hF, 0);
    rd(10'h104, 0);
    check("pba_const", rdata, 32'hCAFE0104);
    // out of window
    rd(10'h200, 0);
    check("oor_raddr_held", raddr, 10'h104);
    wr(10'h3FC, 32'h12345678, 4'hF, 0);
    check("oor_bresp", bresp, 2'b10);
    // partial strobe
    mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    wr(10'h020, 32'hAABBCCDD, 4'b0101, 0);
    check("partial_mem", mem[8], RMW ? 32'h11BB33DD : 32'h11223344);
    check("partial_bresp", bresp, RMW ? 2'b00 : 2'b10);
    // low address bits ignored, zero strobe
    wr(10'h013, 32'h0BADF00D, 4'hF, 0);
    wr(10'h014, 32'h77777777, 4'h0, 0);
    rd(10'h012, 0);
    // backpressure on B holds response and blocks new grants
    wr(10'h018, $urandom, 4'hF, 5);
    // arbitration from reset with both sides eligible every cycle
    reset_dut();
    w0 = we_cnt;
    awaddr = 10'h030; wdata = 32'h5A5A0030; wstrb = 4'hF; araddr = 10'h040;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    g = 0; n = 0; dw = 0; dr = 0;
    for (int i = 0; i < 4; i++) gs[i] = 9;
    while ((awvalid || arvalid) && n < 100) begin
      tick(); n++;
      if (dw) begin awvalid = 0; wvalid = 0; dw = 0; end
      if (dr) begin arvalid = 0; dr = 0; end
      if (awready) begin if (g < 4) gs[g] = 0; g++; dw = g >= 3; end
      if (arready) begin if (g < 4) gs[g] = 1; g++; dr = g >= 3; end
    end
    repeat (12) tick();
    bready = 0; rready = 0;
    check("arb_done", n < 100, 1);
    check("arb_order", {gs[0][3:0], gs[1][3:0], gs[2][3:0], gs[3][3:0]}, 16'h0101);
    check("arb_we", we_cnt - w0, 2);
    ref_mem[12] = 32'h5A5A0030;
    exp_raddr = 10'h040;
    rd(10'h030, 0);
    // asynchronous reset during RD_WAIT
    araddr = 10'h010; arvalid = 1;
    tick();
    check("rst_ar", arready, 1);
    tick();
    arvalid = 0;
    tick();
    rst_n = 0;
    #1;
    check("rst_async", outs, 0);
    #2 rst_n = 1;
    exp_raddr = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_rvalid", {rvalid, bvalid}, 0);
    end
    rd(10'h010, 0);
    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 9);
      a = (k < 7) ? 10'($urandom_range(0, 255)) : (k < 9) ? 10'($urandom_range(256, 511)) : 10'($urandom_range(512, 1023));
      s = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) wr(a, $urandom, s, $urandom_range(0, 3));
      else rd(a, $urandom_range(0, 3));
    end
    check("b_r_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/msix_axil_bridge.md
Name: msix_axil_bridge

Overview:
- AXI4-Lite slave that converts host BAR accesses to the MSI-X table/PBA into the single-port memory interface consumed by the MSI-X manager (waddr/raddr/wdata/rdata/we_norread).
- Sits directly upstream of the MSI-X manager, between the PCIe requester-completer AXI-Lite fabric and the BRAM port B.
- Serialises reads and writes and enforces PBA read-only semantics.
- Provides byte-strobe handling for a memory interface that has no byte enables.

Parameters:
- C_ADDR_WIDTH, 9, byte address width of both AXI and memory sides.
- C_DATA_WIDTH, 32, data width; fixed at 32 (strobe width = 4).
- C_MEM_SIZE_BYTES, 512, decoded window; addresses at or above it are out of range.
- C_PBA_OFFSET, 32'h100, first byte of the PBA region (read-only to host, extends to C_MEM_SIZE_BYTES).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_awaddr  in  C_ADDR_WIDTH  write address
- s_axil_awvalid  in  1 / s_axil_awready  out  1
- s_axil_wdata  in  32 / s_axil_wstrb  in  4 / s_axil_wvalid  in  1 / s_axil_wready  out  1
- s_axil_bresp  out  2 / s_axil_bvalid  out  1 / s_axil_bready  in  1
- s_axil_araddr  in  C_ADDR_WIDTH / s_axil_arvalid  in  1 / s_axil_arready  out  1
- s_axil_rdata  out  32 / s_axil_rresp  out  2 / s_axil_rvalid  out  1 / s_axil_rready  in  1
- m_mem_waddr  out  C_ADDR_WIDTH  word-aligned write address ([1:0]=0)
- m_mem_raddr  out  C_ADDR_WIDTH  word-aligned read address ([1:0]=0)
- m_mem_wdata  out  32  write data
- m_mem_rdata  in  32  read data, valid one cycle after address sampled by BRAM
- m_mem_we_norread  out  1  1 = write this cycle, 0 = read/idle

Behaviour:
- Reset (async, rst_n=0): all ready/valid outputs 0, bresp/rresp 2'b00, rdata 0, m_mem_* 0, state IDLE, priority toggle = write-first. Reset mid-transaction abandons it; no response is issued.
- One transaction at a time; no outstanding overlap.
- IDLE:
  - Write is eligible only when awvalid && wvalid; read is eligible when arvalid.
  - If both are eligible, grant alternates, starting with write after reset; the toggle flips on every grant.
  - Write grant: awready=wready=1 for exactly one cycle; address, data and strb are captured.
  - Read grant: arready=1 for one cycle.
- Write decode on the captured address:
  - Out of range: no memory access, bresp=SLVERR (2'b10).
  - PBA region: write dropped, bresp=OKAY.
  - wstrb=4'h0: no access, OKAY.
  - wstrb=4'hF: WR_EXEC drives we_norread=1 for one cycle with waddr/wdata.
  - Partial strobe: handled per the Optional Feature.
- WR_RESP: bvalid held until bready; then IDLE. Minimum latency for a full-strobe write is 3 cycles from AW/W handshake to bvalid.
- Read path:
  - RD_ADDR: raddr driven, we_norread=0.
  - RD_WAIT: one cycle.
  - RD_CAP: rdata <= m_mem_rdata.
  - RD_RESP: rvalid held until rready; rresp=OKAY.
  - Out of range: skip the memory access, rdata=0, rresp=SLVERR.
  - raddr stays stable from RD_ADDR through RD_CAP.
- Address low bits [1:0] are ignored (forced 0) on both paths.
- we_norread is asserted only in WR_EXEC; m_mem_waddr/raddr hold their last values otherwise.
- bvalid and rvalid are never asserted together.
- Response outputs are stable while valid && !ready.

Optional Feature:
- MSIX_BRIDGE_RMW_EN defined: a partial strobe performs read-modify-write.
  - Sequence: RMW_RD (raddr), RMW_WAIT, RMW_MERGE (new byte where strb=1, else old byte), WR_EXEC, then bresp=OKAY.
  - This adds 3 cycles.
- Not defined: a partial strobe performs no memory access and returns bresp=SLVERR.

Decomposition:
- Shared package msix_pkg:
  - state encoding localparams
  - AXI response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - default C_PBA_OFFSET / C_MEM_SIZE_BYTES
- Sub-module msix_axil_decode (combinational): address-to-{in_range, is_pba} classification, reused by the write and read paths.
- FSM and datapath live in the top module.

Test Plan:
- Write 0xDEADBEEF to 0x010 with strb F, then read 0x010 -> one we_norread pulse with waddr=0x010; bresp OKAY; rdata=0xDEADBEEF, rresp OKAY.
- Write to 0x104 (PBA) with strb F -> no we_norread pulse; bresp OKAY; a later read of 0x104 returns the manager-set value unchanged.
- Read 0x200 (out of range) -> no memory access; rdata=0, rresp SLVERR. Write 0x3FC -> bresp SLVERR.
- Preload 0x11223344 at 0x020, write 0xAABBCCDD with strb 4'b0101:
  - RMW_EN: memory becomes 0x11BB33DD, bresp OKAY.
  - Without RMW_EN: memory unchanged, bresp SLVERR.
- AW/W and AR asserted in the same cycle twice in a row, starting from reset -> first grant write, second read, third write. Hold bready=0 for 5 cycles -> bvalid and bresp stay stable, no new grant.
- Assert rst_n=0 during RD_WAIT -> all outputs 0 asynchronously; after release, the next read completes normally with no stale rvalid.
